ws2812_tx: RTL and testbench

WS2812_TX -- requirements
Module: ws2812_tx

---
 rtl/ws2812_pkg.sv | 14 +
 rtl/ws2812_bit_gen.sv | 34 +++
 rtl/ws2812_tx.sv | 112 +++++++++++
 tb/tb_ws2812_tx.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared timing defaults, state encoding and word reorder for the serial LED transmitters.
package ws2812_pkg;
  localparam int T_BIT_DEF   = 62;
  localparam int T0H_DEF     = 20;
  localparam int T1H_DEF     = 40;
  localparam int T_RESET_DEF = 3000;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, LATCH} state_e;
  function automatic int cnt_w(input int t_reset);
    return ($clog2(t_reset + 1) > 12) ? $clog2(t_reset + 1) : 12;
  endfunction
  function automatic logic [23:0] grb_order(input logic [23:0] w);
    return {w[23:16], w[7:0], w[15:8]};
  endfunction
endpackage

// File: rtl/ws2812_bit_gen.sv
// ws2812_bit_gen: one bit period on the line, high for T1H or T0H clocks then low until T_BIT.
module ws2812_bit_gen import ws2812_pkg::*; #(
  parameter int T_BIT = T_BIT_DEF,
  parameter int T0H   = T0H_DEF,
  parameter int T1H   = T1H_DEF,
  parameter int CW    = 12
) (
  input  logic clk,
  input  logic rst,
  input  logic bit_i,
  input  logic go_i,
  output logic line_o,
  output logic bit_end_o
);
  localparam logic [CW-1:0] LAST = CW'(T_BIT - 1);
  localparam logic [CW-1:0] HI1  = CW'(T1H);
  localparam logic [CW-1:0] HI0  = CW'(T0H);
  logic [CW-1:0] cnt_q, cnt_d;
  logic line_q, line_d;
  always_comb begin
    bit_end_o = go_i && cnt_q == LAST;
    cnt_d = (!go_i || bit_end_o) ? '0 : cnt_q + CW'(1);
    line_d = go_i && cnt_q < (bit_i ? HI1 : HI0);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt_q  <= '0;
      line_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  assign line_o = line_q;
endmodule

// File: rtl/ws2812_tx.sv
// ws2812_tx: frame FSM fetching {G,B,R} words and streaming them gaplessly in G,R,B wire order, then the latch gap.
module ws2812_tx import ws2812_pkg::*; #(
  parameter int NUM_LEDS = 64,
  parameter int T_BIT    = T_BIT_DEF,
  parameter int T0H      = T0H_DEF,
  parameter int T1H      = T1H_DEF,
  parameter int T_RESET  = T_RESET_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [6:0]  led_addr,
  input  logic [23:0] led_data,
  output logic        dout,
  output logic        busy,
  output logic        done
);
  localparam int CW = cnt_w(T_RESET);
  localparam logic [6:0] LAST_ADDR = 7'(NUM_LEDS - 1);
  localparam logic [CW-1:0] LATCH_END = CW'(T_RESET);
  state_e state_q, state_d;
  logic [6:0] addr_q, addr_d;
  logic [23:0] sr_q, sr_d, nxt_q, nxt_d;
  logic [4:0] bcnt_q, bcnt_d;
  logic [CW-1:0] lcnt_q, lcnt_d;
  logic more_q, more_d, busy_q, busy_d, done_q, done_d;
  logic [1:0] en_q;
  logic bit_end;
  ws2812_bit_gen #(.T_BIT(T_BIT), .T0H(T0H), .T1H(T1H), .CW(CW)) u_bit (
    .clk      (clk),
    .rst      (rst),
    .bit_i    (sr_q[23]),
    .go_i     (state_q == SHIFT),
    .line_o   (dout),
    .bit_end_o(bit_end)
  );
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sr_d    = sr_q;
    nxt_d   = nxt_q;
    bcnt_d  = bcnt_q;
    lcnt_d  = '0;
    more_d  = more_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: if (start && en_q[1] && !done_q) begin
        state_d = FETCH;
        addr_d  = '0;
        busy_d  = 1'b1;
      end
      FETCH: begin
        sr_d    = grb_order(led_data);
        bcnt_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: if (bit_end) begin
        sr_d   = {sr_q[22:0], 1'b0};
        bcnt_d = bcnt_q + 5'd1;
        // Next address goes out during bit 22 so the word is ready by bit 23.
        if (bcnt_q == 5'd21) begin
          more_d = addr_q != LAST_ADDR;
          addr_d = (addr_q != LAST_ADDR) ? addr_q + 7'd1 : addr_q;
        end
        if (bcnt_q == 5'd22) nxt_d = led_data;
        if (bcnt_q == 5'd23) begin
          bcnt_d  = '0;
          sr_d    = grb_order(nxt_q);
          state_d = more_q ? SHIFT : LATCH;
        end
      end
      LATCH: begin
        lcnt_d = lcnt_q + CW'(1);
        if (lcnt_q == LATCH_END) begin
          lcnt_d  = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      sr_q    <= '0;
      nxt_q   <= '0;
      bcnt_q  <= '0;
      lcnt_q  <= '0;
      more_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      en_q    <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sr_q    <= sr_d;
      nxt_q   <= nxt_d;
      bcnt_q  <= bcnt_d;
      lcnt_q  <= lcnt_d;
      more_q  <= more_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      en_q    <= {en_q[0], 1'b1};
    end
  assign led_addr = addr_q;
  assign busy     = busy_q;
  assign done     = done_q;
endmodule

// File: tb/tb_ws2812_tx.sv
// tb_ws2812_tx: captures the serial line per frame and decodes it against GRB-reordered source words.
module tb_ws2812_tx;
  localparam int BN = 64, BT = 8, B0 = 3, B1 = 5, BR = 100;
  localparam int OT = 62, O0 = 20, O1 = 40, OR = 3000;
  localparam int DA = 2 + 24 * BN * BT + BR;
  localparam int DB = 2 + 24 * OT + OR;
  logic clk = 0, rst = 0, start_a = 0, start_b = 0;
  logic [6:0] addr_a, addr_b;
  logic [23:0] data_a = '0, data_b = '0;
  logic dout_a, dout_b, busy_a, busy_b, done_a, done_b;
  logic [23:0] mem_a [BN];
  logic [23:0] mem_b = '0;
  int pass_n = 0, total_n = 0;
  typedef struct {logic [23:0] word; logic [23:0] wire_w; bit poke;} vec_t;
  vec_t vecs [3];
  logic q_d[$], q_b[$], q_n[$];
  int q_a[$];
  logic [23:0] dec[$];

  always #10 clk = ~clk;

  // Source memory: data for the current address is ready by the next rising edge.
  always @(negedge clk) begin
    data_a = (addr_a < 7'(BN)) ? mem_a[addr_a[5:0]] : 24'h5A5A5A;
    data_b = (addr_b == 7'd0) ? mem_b : 24'h5A5A5A;
  end

  ws2812_tx #(.NUM_LEDS(BN), .T_BIT(BT), .T0H(B0), .T1H(B1), .T_RESET(BR)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .led_addr(addr_a), .led_data(data_a),
    .dout(dout_a), .busy(busy_a), .done(done_a)
  );
  ws2812_tx #(.NUM_LEDS(1)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .led_addr(addr_b), .led_data(data_b),
    .dout(dout_b), .busy(busy_b), .done(done_b)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total_n++;
    if (act == exp) pass_n++;
    else $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  function automatic logic [23:0] wire_of(input logic [23:0] w);
    logic [7:0] g, b, r;
    g = w[23:16];
    b = w[15:8];
    r = w[7:0];
    return {g, r, b};
  endfunction

  task automatic frame(input int s, input int d, input bit poke);
    q_d.delete(); q_b.delete(); q_n.delete(); q_a.delete();
    @(negedge clk);
    if (s == 1) start_b = 1; else start_a = 1;
    @(posedge clk);
    @(negedge clk);
    start_a = 0;
    start_b = 0;
    for (int j = 0; j <= d + 3; j++) begin
      q_d.push_back(s == 1 ? dout_b : dout_a);
      q_b.push_back(s == 1 ? busy_b : busy_a);
      q_n.push_back(s == 1 ? done_b : done_a);
      q_a.push_back(int'(s == 1 ? addr_b : addr_a));
      if (poke) begin
        if (s == 1) start_b = (j == d / 2 || j == d); else start_a = (j == d / 2 || j == d);
      end
      @(negedge clk);
    end
    start_a = 0;
    start_b = 0;
  endtask

  task automatic ctrl(input int nl, input int t, input int tr);
    int d = 2 + 24 * nl * t + tr;
    int bb = -1, fd = -1, nd = 0, lb = -1, mx = 0;
    for (int j = 0; j < q_d.size(); j++) begin
      if (q_b[j] != (j < d) && bb < 0) bb = j;
      if (q_n[j]) begin
        nd++;
        if (fd < 0) fd = j;
      end
      if ((j < 2 || j >= d - tr) && q_d[j] && lb < 0) lb = j;
      if (q_a[j] > mx) mx = q_a[j];
    end
    chk("busy_window", bb, -1);
    chk("done_at", fd, d);
    chk("done_count", nd, 1);
    chk("line_low", lb, -1);
    chk("addr_max", mx, nl - 1);
    chk("addr_first", q_a[0], 0);
    chk("addr_hold", q_a[q_a.size() - 1], nl - 1);
  endtask

  task automatic decode(input int nl, input int t, input int t0, input int t1);
    int bad = -1;
    dec.delete();
    for (int i = 0; i < nl; i++) begin
      logic [23:0] w;
      w = '0;
      for (int b = 0; b < 24; b++) begin
        int st, ones;
        bit ok;
        st = 2 + (i * 24 + b) * t;
        ones = 0;
        for (int c = 0; c < t; c++) if (q_d[st + c]) ones++;
        ok = (ones == t0 || ones == t1);
        for (int c = 0; c < t; c++) if (q_d[st + c] != (c < ones)) ok = 0;
        if (!ok && bad < 0) bad = i * 24 + b;
        w = {w[22:0], ones == t1};
      end
      dec.push_back(w);
    end
    chk("bit_timing", bad, -1);
  endtask

  initial begin
    vecs[0] = '{24'hFF0000, 24'hFF0000, 1'b0};
    vecs[1] = '{24'h123456, 24'h125634, 1'b1};
    vecs[2] = '{24'h0000FF, 24'h00FF00, 1'b0};
    for (int i = 0; i < BN; i++) mem_a[i] = '0;
    repeat (3) @(negedge clk);
    chk("rst_dout_a", dout_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_done_a", done_a, 0);
    chk("rst_addr_a", addr_a, 0);
    chk("rst_dout_b", dout_b, 0);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_addr_b", addr_b, 0);
    rst = 1;
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      mem_b = vecs[i].word;
      frame(1, DB, vecs[i].poke);
      ctrl(1, OT, OR);
      decode(1, OT, O0, O1);
      chk($sformatf("tbl%0d_word", i), dec[0], vecs[i].wire_w);
      repeat (5) @(negedge clk);
    end
    for (int i = 0; i < BN; i++) mem_a[i] = 24'($urandom());
    mem_a[0] = 24'h00FF00;
    mem_a[1] = 24'h0000FF;
    frame(0, DA, 0);
    ctrl(BN, BT, BR);
    decode(BN, BT, B0, B1);
    chk("led0_wire", dec[0], 24'h0000FF);
    chk("led1_wire", dec[1], 24'h00FF00);
    for (int i = 2; i < BN; i++) chk($sformatf("pair_led%0d", i), dec[i], wire_of(mem_a[i]));
    repeat (5) @(negedge clk);
    for (int i = 0; i < BN; i++) mem_a[i] = 24'hFFFFFF;
    @(negedge clk);
    start_a = 1;
    @(posedge clk);
    @(negedge clk);
    start_a = 0;
    repeat (2 + (3 * 24 + 10) * BT + 1) @(negedge clk);
    chk("pre_rst_dout", dout_a, 1);
    chk("pre_rst_addr", addr_a, 3);
    #2 rst = 0;
    #1;
    chk("mid_rst_dout", dout_a, 0);
    chk("mid_rst_busy", busy_a, 0);
    chk("mid_rst_addr", addr_a, 0);
    @(negedge clk);
    rst = 1;
    repeat (20) @(negedge clk);
    chk("idle_busy", busy_a, 0);
    chk("idle_dout", dout_a, 0);
    for (int i = 0; i < BN; i++) mem_a[i] = 24'($urandom());
    frame(0, DA, 0);
    ctrl(BN, BT, BR);
    decode(BN, BT, B0, B1);
    for (int i = 0; i < BN; i++) chk($sformatf("rnd_led%0d", i), dec[i], wire_of(mem_a[i]));
    $display("%0d/%0d checks passed", pass_n, total_n);
    $finish;
  end
endmodule
